// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage producing the IF/ID pipeline register
package fetch_stage_pkg;
  typedef struct packed {
    logic [31:0] pc_cur;
    logic [31:0] instruction;
  } if_to_id_t;
endpackage

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output if_to_id_t   IF_to_ID,
  output logic        if_valid
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_drop;
  logic [31:0] r_hold;
  if_to_id_t   r_if;
  logic        r_if_valid;

  state_t      w_state;
  logic [31:0] w_pc;
  logic        w_drop;
  logic [31:0] w_hold;
  if_to_id_t   w_if;
  logic        w_if_valid;

  logic        w_free;
  logic        w_handshake;
  logic [31:0] w_pc_inc;
  logic [31:0] w_target;

  // IF/ID can take a new instruction when Decode is not stalled or the register is empty
  assign w_free      = !stall || !r_if_valid;
  assign w_handshake = (r_state == S_ISSUE) && imem_req_ready;
  assign w_pc_inc    = r_pc + 32'd4;
  assign w_target    = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req_valid = (r_state == S_ISSUE) && !reset;
  assign imem_req_addr  = r_pc;
  assign IF_to_ID       = r_if;
  assign if_valid       = r_if_valid;

  // Next-state logic: fetch FSM, PC update, and IF/ID load/bubble/flush
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_drop     = r_drop;
    w_hold     = r_hold;
    w_if       = r_if;
    w_if_valid = r_if_valid;

    // A free register with nothing new becomes a bubble; pc_cur is left as-is
    if (w_free) begin
      w_if_valid       = 1'b0;
      w_if.instruction = NOP_INSTR;
    end

    if (redirect) begin
      w_if_valid       = 1'b0;
      w_if.instruction = NOP_INSTR;
      w_pc             = w_target;
      unique case (r_state)
        S_ISSUE: begin
          // A request accepted this cycle is wrong-path; its response must be dropped
          if (w_handshake) begin
            w_state = S_WAIT;
            w_drop  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            w_state = S_ISSUE;
            w_drop  = 1'b0;
          end else begin
            w_drop  = 1'b1;
          end
        end
        S_HOLD: begin
          w_state = S_ISSUE;
        end
        default: w_state = S_ISSUE;
      endcase
    end else begin
      unique case (r_state)
        S_ISSUE: begin
          if (w_handshake) w_state = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (r_drop) begin
              w_drop  = 1'b0;
              w_state = S_ISSUE;
            end else if (w_free) begin
              w_if.pc_cur      = r_pc;
              w_if.instruction = imem_resp_data;
              w_if_valid       = 1'b1;
              w_pc             = w_pc_inc;
              w_state          = S_ISSUE;
            end else begin
              w_hold  = imem_resp_data;
              w_state = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_free) begin
            w_if.pc_cur      = r_pc;
            w_if.instruction = r_hold;
            w_if_valid       = 1'b1;
            w_pc             = w_pc_inc;
            w_state          = S_ISSUE;
          end
        end
        default: w_state = S_ISSUE;
      endcase
    end
  end

  // State registers with synchronous reset overriding every other input
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state            <= S_ISSUE;
      r_pc               <= RESET_PC;
      r_drop             <= 1'b0;
      r_hold             <= 32'd0;
      r_if.pc_cur        <= 32'd0;
      r_if.instruction   <= NOP_INSTR;
      r_if_valid         <= 1'b0;
    end else begin
      r_state            <= w_state;
      r_pc               <= w_pc;
      r_drop             <= w_drop;
      r_hold             <= w_hold;
      r_if               <= w_if;
      r_if_valid         <= w_if_valid;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  if_to_id_t   IF_to_ID;
  logic        if_valid;

  int total = 0;
  int bad   = 0;
  int mem_lat = 1;
  logic [31:0] exp_q[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .IF_to_ID       (IF_to_ID),
    .if_valid       (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: one outstanding request, response after mem_lat cycles
  initial begin : mem_model
    logic        pend;
    int          cnt;
    logic [31:0] pdata;
    pend = 1'b0;
    cnt = 0;
    pdata = 32'd0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    forever begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready && !pend) begin
        pend = 1'b1;
        cnt = mem_lat;
        pdata = mem_word(imem_req_addr);
      end
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data = pdata;
          pend = 1'b0;
        end
      end
    end
  end

  // Decode side: every instruction consumed must be the next expected pc in order
  initial begin : monitor
    logic [31:0] epc;
    forever begin
      @(negedge clk);
      if (!reset && if_valid && !stall) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_instr", 32'(exp_q.size()), 32'd1);
        end else begin
          epc = exp_q.pop_front();
          chk("sb_pc", IF_to_ID.pc_cur, epc);
          chk("sb_instr", IF_to_ID.instruction, mem_word(epc));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'd0;
    imem_req_ready = 1'b0;

    cyc();
    cyc();
    @(negedge clk);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_pc_cur", IF_to_ID.pc_cur, 32'd0);
    chk("rst_instr", IF_to_ID.instruction, NOP);

    // Streaming fetch from RESET_PC
    cyc();
    reset = 1'b0;
    imem_req_ready = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    @(negedge clk);
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_req_addr0", imem_req_addr, 32'h0);
    cyc();
    @(negedge clk);
    chk("t1_wait_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t1_wait_if_valid", 32'(if_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("t1_first_valid", 32'(if_valid), 32'd1);
    chk("t1_first_pc", IF_to_ID.pc_cur, 32'h0);
    chk("t1_first_instr", IF_to_ID.instruction, 32'hA5A5_0000);
    chk("t1_req_addr4", imem_req_addr, 32'h4);
    cyc();
    @(negedge clk);
    chk("t1_bubble_valid", 32'(if_valid), 32'd0);
    chk("t1_bubble_instr", IF_to_ID.instruction, NOP);
    chk("t1_bubble_pc", IF_to_ID.pc_cur, 32'h0);

    // Stall across the response for pc 0x8
    cyc();
    stall = 1'b1;
    @(negedge clk);
    chk("t2_pc4_valid", 32'(if_valid), 32'd1);
    chk("t2_pc4", IF_to_ID.pc_cur, 32'h4);
    chk("t2_req_addr8", imem_req_addr, 32'h8);
    cyc();
    @(negedge clk);
    chk("t2_stall1_pc", IF_to_ID.pc_cur, 32'h4);
    cyc();
    @(negedge clk);
    chk("t2_stall2_pc", IF_to_ID.pc_cur, 32'h4);
    chk("t2_hold_req_valid", 32'(imem_req_valid), 32'd0);
    cyc();
    stall = 1'b0;
    @(negedge clk);
    chk("t2_release_pc", IF_to_ID.pc_cur, 32'h4);
    cyc();
    mem_lat = 2;
    @(negedge clk);
    chk("t2_pc8_valid", 32'(if_valid), 32'd1);
    chk("t2_pc8", IF_to_ID.pc_cur, 32'h8);
    chk("t2_req_addrc", imem_req_addr, 32'hC);

    // Redirect in WAIT, stale response arrives afterwards
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    chk("t3_wait_req_valid", 32'(imem_req_valid), 32'd0);
    cyc();
    redirect = 1'b0;
    mem_lat = 1;
    @(negedge clk);
    chk("t3_drop_if_valid", 32'(if_valid), 32'd0);
    chk("t3_drop_req_valid", 32'(imem_req_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("t3_after_if_valid", 32'(if_valid), 32'd0);
    chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t3_req_addr", imem_req_addr, 32'h100);

    // Redirect together with stall and a response
    cyc();
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    chk("t4_resp_present", 32'(imem_resp_valid), 32'd1);
    cyc();
    stall = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_if_valid", 32'(if_valid), 32'd0);
    chk("t4_instr", IF_to_ID.instruction, NOP);
    chk("t4_req_addr", imem_req_addr, 32'h200);
    cyc();
    cyc();
    stall = 1'b1;
    @(negedge clk);
    chk("t4b_pc200", IF_to_ID.pc_cur, 32'h200);
    chk("t4b_valid", 32'(if_valid), 32'd1);
    cyc();
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    chk("t4b_hold_pc", IF_to_ID.pc_cur, 32'h200);
    chk("t4b_hold_req_valid", 32'(imem_req_valid), 32'd0);

    // Request back-pressure for 5 cycles
    cyc();
    redirect = 1'b0;
    stall = 1'b0;
    imem_req_ready = 1'b0;
    exp_q.push_back(32'h300);
    @(negedge clk);
    chk("t4b_flush_valid", 32'(if_valid), 32'd0);
    chk("t4b_flush_instr", IF_to_ID.instruction, NOP);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      if (i > 0) @(negedge clk);
      chk("t5_bp_req_valid", 32'(imem_req_valid), 32'd1);
      chk("t5_bp_req_addr", imem_req_addr, 32'h300);
    end
    cyc();
    imem_req_ready = 1'b1;
    @(negedge clk);
    chk("t5_accept_addr", imem_req_addr, 32'h300);
    cyc();
    @(negedge clk);
    chk("t5_wait_req_valid", 32'(imem_req_valid), 32'd0);
    cyc();
    cyc();
    mem_lat = 2;
    @(negedge clk);
    chk("t5_pc300", IF_to_ID.pc_cur, 32'h300);
    chk("t5_req_addr304", imem_req_addr, 32'h304);

    // Reset in WAIT with a late response afterwards
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    cyc();
    reset = 1'b0;
    mem_lat = 1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    chk("t6_late_if_valid", 32'(if_valid), 32'd0);
    chk("t6_late_instr", IF_to_ID.instruction, NOP);
    chk("t6_late_pc", IF_to_ID.pc_cur, 32'h0);
    chk("t6_req_addr", imem_req_addr, 32'h0);
    cyc();
    cyc();
    redirect = 1'b1;
    redirect_pc = 32'h3;
    @(negedge clk);
    chk("t6_pc0_instr", IF_to_ID.instruction, 32'hA5A5_0000);
    chk("t6_req_addr4", imem_req_addr, 32'h4);
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    chk("t6_redir_if_valid", 32'(if_valid), 32'd0);
    cyc();
    @(negedge clk);
    chk("t6_misaligned_addr", imem_req_addr, 32'h0);
    chk("t6_misaligned_valid", 32'(imem_req_valid), 32'd1);
    cyc();

    // Redirect in ISSUE without acceptance, then PC wrap-around
    cyc();
    imem_req_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect = 1'b0;
    imem_req_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    @(negedge clk);
    chk("t7_new_addr", imem_req_addr, 32'hFFFF_FFFC);
    cyc();
    cyc();
    @(negedge clk);
    chk("t7_wrap_addr", imem_req_addr, 32'h0);
    chk("t7_top_pc", IF_to_ID.pc_cur, 32'hFFFF_FFFC);
    cyc();
    cyc();
    imem_req_ready = 1'b0;
    @(negedge clk);
    chk("t7_wrapped_pc", IF_to_ID.pc_cur, 32'h0);
    chk("t7_next_addr", imem_req_addr, 32'h4);
    cyc();
    cyc();
    cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
